sdram_width_adapter: RTL

SDRAM_WIDTH_ADAPTER -- requirements
Module: sdram_width_adapter

---
 rtl/sdram_pkg.sv | 23 ++
 rtl/sdram_width_adapter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared types and widths for the 32-bit CPU to 16-bit SDRAM width adapter.
package sdram_pkg;

    localparam int unsigned C_ADDR_W = 30;
    localparam int unsigned H_ADDR_W = 31;
    localparam int unsigned H_DATA_W = 16;
    localparam int unsigned C_DATA_W = 32;
    localparam int unsigned C_BE_W   = 4;
    localparam int unsigned H_BE_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Expands a halfword's two byte enables into a 16-bit data mask.
    function automatic logic [H_DATA_W-1:0] lane_mask(input logic [H_BE_W-1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sdram_width_adapter.sv
// Splits each 32-bit CPU access into up to two 16-bit SDRAM controller accesses,
// skipping halves whose byte enables are clear.
module sdram_width_adapter
    import sdram_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                c_req,
    input  logic [C_ADDR_W-1:0] c_addr,
    input  logic                c_wr_en,
    input  logic [C_BE_W-1:0]   c_be,
    input  logic [C_DATA_W-1:0] c_wdata,
    output logic [C_DATA_W-1:0] c_rdata,
    output logic                c_ack,
    output logic [H_ADDR_W-1:0] h_addr,
    output logic [H_DATA_W-1:0] h_wdata,
    input  logic [H_DATA_W-1:0] h_rdata,
    output logic                h_wr_en,
    output logic [H_BE_W-1:0]   h_bytesel,
    input  logic                h_compl,
    input  logic                h_config_done
);

    state_t                state, state_d;
    logic [C_ADDR_W-1:0]   addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [C_BE_W-1:0]     be_q, be_d;
    logic [C_DATA_W-1:0]   wdata_q, wdata_d;
    logic [C_DATA_W-1:0]   c_rdata_d;
    logic                  c_ack_d;
    logic [H_ADDR_W-1:0]   h_addr_d;
    logic [H_DATA_W-1:0]   h_wdata_d;
    logic                  h_wr_en_d;
    logic [H_BE_W-1:0]     h_bytesel_d;

    // State, latched request and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            c_rdata   <= '0;
            c_ack     <= 1'b0;
            h_addr    <= '0;
            h_wdata   <= '0;
            h_wr_en   <= 1'b0;
            h_bytesel <= '0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            c_rdata   <= c_rdata_d;
            c_ack     <= c_ack_d;
            h_addr    <= h_addr_d;
            h_wdata   <= h_wdata_d;
            h_wr_en   <= h_wr_en_d;
            h_bytesel <= h_bytesel_d;
        end
    end

    // Next state plus next values of the output registers; h_bytesel drops to 0 by default.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        wr_d        = wr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        c_rdata_d   = c_rdata;
        c_ack_d     = 1'b0;
        h_addr_d    = h_addr;
        h_wdata_d   = h_wdata;
        h_wr_en_d   = h_wr_en;
        h_bytesel_d = '0;

        unique case (state)
            IDLE: begin
                if (c_req && h_config_done) begin
                    addr_d    = c_addr;
                    wr_d      = c_wr_en;
                    be_d      = c_be;
                    wdata_d   = c_wdata;
                    c_rdata_d = '0;
                    h_wr_en_d = c_wr_en;
                    if (c_be[1:0] != 2'b00) begin
                        state_d     = LO;
                        h_addr_d    = {c_addr, 1'b0};
                        h_bytesel_d = c_be[1:0];
                        h_wdata_d   = c_wdata[15:0];
                    end else if (c_be[3:2] != 2'b00) begin
                        state_d     = HI;
                        h_addr_d    = {c_addr, 1'b1};
                        h_bytesel_d = c_be[3:2];
                        h_wdata_d   = c_wdata[31:16];
                    end else begin
                        state_d = DONE;
                        c_ack_d = 1'b1;
                    end
                end
            end
            LO: begin
                h_bytesel_d = h_bytesel;
                if (h_compl) begin
                    if (!wr_q) begin
                        c_rdata_d[15:0] = h_rdata & lane_mask(be_q[1:0]);
                    end
                    if (be_q[3:2] != 2'b00) begin
                        state_d     = HI;
                        h_addr_d    = {addr_q, 1'b1};
                        h_bytesel_d = be_q[3:2];
                        h_wdata_d   = wdata_q[31:16];
                    end else begin
                        state_d     = DONE;
                        c_ack_d     = 1'b1;
                        h_bytesel_d = '0;
                    end
                end
            end
            HI: begin
                h_bytesel_d = h_bytesel;
                if (h_compl) begin
                    if (!wr_q) begin
                        c_rdata_d[31:16] = h_rdata & lane_mask(be_q[3:2]);
                    end
                    state_d     = DONE;
                    c_ack_d     = 1'b1;
                    h_bytesel_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
